// File: rtl/pl_nn_axil_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pl_nn_axil_slave
//  Description : AXI4-Lite slave fronting the perceptron image/weight BRAMs
//                and a small control block (CTRL start, STATUS done_sticky).
//                Independent write and read FSMs share one BRAM port; the
//                write side wins when both want it in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pl_nn_axil_slave #(
    parameter int IMG_WORDS = 784,
    parameter int WGT_WORDS = 784
) (
    input  logic        ACLK,
    input  logic        ARESET,
    // write address channel
    input  logic [13:0] S_AXI_awaddr,
    input  logic [2:0]  S_AXI_awprot,
    input  logic        S_AXI_awvalid,
    output logic        S_AXI_awready,
    // write data channel
    input  logic [31:0] S_AXI_wdata,
    input  logic [3:0]  S_AXI_wstrb,
    input  logic        S_AXI_wvalid,
    output logic        S_AXI_wready,
    // write response channel
    output logic [1:0]  S_AXI_bresp,
    output logic        S_AXI_bvalid,
    input  logic        S_AXI_bready,
    // read address channel
    input  logic [13:0] S_AXI_araddr,
    input  logic [2:0]  S_AXI_arprot,
    input  logic        S_AXI_arvalid,
    output logic        S_AXI_arready,
    // read data channel
    output logic [31:0] S_AXI_rdata,
    output logic [1:0]  S_AXI_rresp,
    output logic        S_AXI_rvalid,
    input  logic        S_AXI_rready,
    // shared BRAM port
    output logic        mem_en,
    output logic        mem_sel,
    output logic [9:0]  mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata_img,
    input  logic [31:0] mem_rdata_wgt,
    // perceptron datapath handshake
    output logic        start,
    input  logic        done
);

    localparam logic [1:0]  c_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  c_RESP_SLVERR = 2'b10;
    localparam logic [1:0]  c_RGN_IMG     = 2'b00;
    localparam logic [1:0]  c_RGN_WGT     = 2'b01;
    localparam logic [1:0]  c_RGN_CTRL    = 2'b10;
    localparam logic [9:0]  c_IDX_CTRL    = 10'd0;
    localparam logic [9:0]  c_IDX_STATUS  = 10'd1;
    localparam logic [31:0] c_IMG_LIMIT   = IMG_WORDS;
    localparam logic [31:0] c_WGT_LIMIT   = WGT_WORDS;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_EXEC = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_EXEC = 2'd1,
        R_CAPT = 2'd2,
        R_RESP = 2'd3
    } rstate_t;

    // True when an address falls outside every implemented word.
    function automatic logic addr_err(input logic [13:0] a);
        logic [31:0] idx;
        idx = {22'd0, a[11:2]};
        case (a[13:12])
            c_RGN_IMG:  return (idx >= c_IMG_LIMIT);
            c_RGN_WGT:  return (idx >= c_WGT_LIMIT);
            c_RGN_CTRL: return (a[11:2] != c_IDX_CTRL) && (a[11:2] != c_IDX_STATUS);
            default:    return 1'b1;
        endcase
    endfunction

    wstate_t     r_wstate;
    logic [13:0] r_awaddr;
    logic        r_aw_ok;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_w_ok;
    logic        r_awready;
    logic        r_wready;
    logic        r_bvalid;
    logic [1:0]  r_bresp;
    logic        r_start;

    rstate_t     r_rstate;
    logic [13:0] r_araddr;
    logic        r_arready;
    logic        r_rvalid;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;

    logic        r_done_sticky;

    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_wr_err;
    logic        w_wr_mem;
    logic        w_rd_err;
    logic        w_rd_mem;
    logic        w_rd_stall;
    logic        w_wr_issue;
    logic        w_rd_issue;
    logic        w_ctrl_fire;
    logic [31:0] w_rd_value;
    logic        w_unused_ok;

    assign w_aw_hs     = S_AXI_awvalid & r_awready;
    assign w_w_hs      = S_AXI_wvalid  & r_wready;
    assign w_wr_err    = addr_err(r_awaddr);
    assign w_wr_mem    = !w_wr_err && !r_awaddr[13];
    assign w_rd_err    = addr_err(r_araddr);
    assign w_rd_mem    = !w_rd_err && !r_araddr[13];
    // Write owns the shared port whenever both FSMs are executing together.
    assign w_rd_stall  = (r_rstate == R_EXEC) && (r_wstate == W_EXEC);
    assign w_wr_issue  = (r_wstate == W_EXEC) && w_wr_mem && !ARESET;
    assign w_rd_issue  = (r_rstate == R_EXEC) && !w_rd_stall && w_rd_mem && !ARESET;
    assign w_ctrl_fire = (r_wstate == W_EXEC) && !w_wr_err && r_awaddr[13]
                         && (r_awaddr[11:2] == c_IDX_CTRL) && r_wstrb[0] && r_wdata[0];

    assign mem_en    = w_wr_issue | w_rd_issue;
    assign mem_sel   = w_wr_issue ? r_awaddr[12]   : (w_rd_issue ? r_araddr[12]   : 1'b0);
    assign mem_addr  = w_wr_issue ? r_awaddr[11:2] : (w_rd_issue ? r_araddr[11:2] : 10'd0);
    assign mem_we    = w_wr_issue ? r_wstrb  : 4'd0;
    assign mem_wdata = w_wr_issue ? r_wdata  : 32'd0;

    // Read data selection for the capture cycle (BRAM data is one cycle after issue).
    always_comb begin
        w_rd_value = 32'd0;
        if (!w_rd_err) begin
            case (r_araddr[13:12])
                c_RGN_IMG:  w_rd_value = mem_rdata_img;
                c_RGN_WGT:  w_rd_value = mem_rdata_wgt;
                c_RGN_CTRL: begin
                    if (r_araddr[11:2] == c_IDX_STATUS) begin
                        w_rd_value = {31'd0, r_done_sticky};
                    end
                end
                default:    w_rd_value = 32'd0;
            endcase
        end
    end

    // Write FSM: latch AW and W independently, execute one cycle, hold response.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate  <= W_IDLE;
            r_awaddr  <= 14'd0;
            r_aw_ok   <= 1'b0;
            r_wdata   <= 32'd0;
            r_wstrb   <= 4'd0;
            r_w_ok    <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_RESP_OKAY;
            r_start   <= 1'b0;
        end else begin
            r_start <= 1'b0;
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awaddr  <= S_AXI_awaddr;
                        r_aw_ok   <= 1'b1;
                        r_awready <= 1'b0;
                    end else if (!r_aw_ok) begin
                        r_awready <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wdata  <= S_AXI_wdata;
                        r_wstrb  <= S_AXI_wstrb;
                        r_w_ok   <= 1'b1;
                        r_wready <= 1'b0;
                    end else if (!r_w_ok) begin
                        r_wready <= 1'b1;
                    end
                    if ((r_aw_ok || w_aw_hs) && (r_w_ok || w_w_hs)) begin
                        r_wstate <= W_EXEC;
                    end
                end
                W_EXEC: begin
                    r_start  <= w_ctrl_fire;
                    r_bresp  <= w_wr_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    r_bvalid <= 1'b1;
                    r_aw_ok  <= 1'b0;
                    r_w_ok   <= 1'b0;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (S_AXI_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read FSM: accept address, issue (retry if write holds the port), capture, respond.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate  <= R_IDLE;
            r_araddr  <= 14'd0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rresp   <= c_RESP_OKAY;
            r_rdata   <= 32'd0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (S_AXI_arvalid && r_arready) begin
                        r_araddr  <= S_AXI_araddr;
                        r_arready <= 1'b0;
                        r_rstate  <= R_EXEC;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_EXEC: begin
                    if (!w_rd_stall) begin
                        r_rstate <= R_CAPT;
                    end
                end
                R_CAPT: begin
                    r_rdata  <= w_rd_value;
                    r_rresp  <= w_rd_err ? c_RESP_SLVERR : c_RESP_OKAY;
                    r_rvalid <= 1'b1;
                    r_rstate <= R_RESP;
                end
                R_RESP: begin
                    if (S_AXI_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    // Sticky completion flag: done sets it, the start pulse clears it, set wins.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_done_sticky <= 1'b0;
        end else if (done) begin
            r_done_sticky <= 1'b1;
        end else if (r_start) begin
            r_done_sticky <= 1'b0;
        end
    end

    assign S_AXI_awready = r_awready;
    assign S_AXI_wready  = r_wready;
    assign S_AXI_bvalid  = r_bvalid;
    assign S_AXI_bresp   = r_bresp;
    assign S_AXI_arready = r_arready;
    assign S_AXI_rvalid  = r_rvalid;
    assign S_AXI_rresp   = r_rresp;
    assign S_AXI_rdata   = r_rdata;
    assign start         = r_start;

    // Protection bits and byte offsets carry no meaning for this slave.
    assign w_unused_ok = ^{S_AXI_awprot, S_AXI_arprot, r_awaddr[1:0], r_araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_pl_nn_axil_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pl_nn_axil_slave
//  Description : Self-checking bench for pl_nn_axil_slave with BRAM emulation
//                and a word-array reference model of the register map.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pl_nn_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [13:0] S_AXI_awaddr = '0;
    logic [2:0]  S_AXI_awprot = '0;
    logic        S_AXI_awvalid = 1'b0;
    logic        S_AXI_awready;
    logic [31:0] S_AXI_wdata = '0;
    logic [3:0]  S_AXI_wstrb = '0;
    logic        S_AXI_wvalid = 1'b0;
    logic        S_AXI_wready;
    logic [1:0]  S_AXI_bresp;
    logic        S_AXI_bvalid;
    logic        S_AXI_bready = 1'b1;
    logic [13:0] S_AXI_araddr = '0;
    logic [2:0]  S_AXI_arprot = '0;
    logic        S_AXI_arvalid = 1'b0;
    logic        S_AXI_arready;
    logic [31:0] S_AXI_rdata;
    logic [1:0]  S_AXI_rresp;
    logic        S_AXI_rvalid;
    logic        S_AXI_rready = 1'b1;
    logic        mem_en;
    logic        mem_sel;
    logic [9:0]  mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata_img = '0;
    logic [31:0] mem_rdata_wgt = '0;
    logic        start;
    logic        done = 1'b0;

    always #5 ACLK = ~ACLK;

    pl_nn_axil_slave #(.IMG_WORDS(784), .WGT_WORDS(784)) u_dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_awaddr(S_AXI_awaddr), .S_AXI_awprot(S_AXI_awprot),
        .S_AXI_awvalid(S_AXI_awvalid), .S_AXI_awready(S_AXI_awready),
        .S_AXI_wdata(S_AXI_wdata), .S_AXI_wstrb(S_AXI_wstrb),
        .S_AXI_wvalid(S_AXI_wvalid), .S_AXI_wready(S_AXI_wready),
        .S_AXI_bresp(S_AXI_bresp), .S_AXI_bvalid(S_AXI_bvalid), .S_AXI_bready(S_AXI_bready),
        .S_AXI_araddr(S_AXI_araddr), .S_AXI_arprot(S_AXI_arprot),
        .S_AXI_arvalid(S_AXI_arvalid), .S_AXI_arready(S_AXI_arready),
        .S_AXI_rdata(S_AXI_rdata), .S_AXI_rresp(S_AXI_rresp),
        .S_AXI_rvalid(S_AXI_rvalid), .S_AXI_rready(S_AXI_rready),
        .mem_en(mem_en), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata_img(mem_rdata_img), .mem_rdata_wgt(mem_rdata_wgt),
        .start(start), .done(done)
    );

    // ---------------- BRAM emulation and port monitor ----------------
    logic [31:0] img_bram [1024];
    logic [31:0] wgt_bram [1024];
    logic        rd_pend = 1'b0;
    logic        rd_pend_sel = 1'b0;
    logic [9:0]  rd_pend_addr = '0;
    int          en_cnt = 0, wr_cnt = 0, start_cnt = 0, start_bad = 0;
    logic        last_wr_sel = 1'b0;
    logic [9:0]  last_wr_addr = '0;
    logic [3:0]  last_wr_we = '0;
    logic [31:0] last_wr_data = '0;

    always @(negedge ACLK) begin
        rd_pend = 1'b0;
        if (mem_en) begin
            en_cnt++;
            if (mem_we == 4'd0) begin
                rd_pend      = 1'b1;
                rd_pend_sel  = mem_sel;
                rd_pend_addr = mem_addr;
            end else begin
                wr_cnt++;
                last_wr_sel  = mem_sel;
                last_wr_addr = mem_addr;
                last_wr_we   = mem_we;
                last_wr_data = mem_wdata;
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) begin
                        if (mem_sel) wgt_bram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                        else         img_bram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                end
            end
        end
        if (start) begin
            start_cnt++;
            if (!S_AXI_bvalid) start_bad++;
        end
    end

    always @(posedge ACLK) begin
        if (rd_pend) begin
            if (rd_pend_sel) mem_rdata_wgt <= wgt_bram[rd_pend_addr];
            else             mem_rdata_img <= img_bram[rd_pend_addr];
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_img [1024];
    logic [31:0] ref_wgt [1024];
    bit          ref_sticky = 1'b0;

    function automatic bit model_err(input int a);
        int region, idx;
        region = a / 4096;
        idx    = (a % 4096) / 4;
        if (region == 0) return idx >= 784;
        if (region == 1) return idx >= 784;
        if (region == 2) return idx > 1;
        return 1'b1;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- bus tasks (start and end at #1 after posedge) ----------------
    task automatic axi_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int bstall, output logic [1:0] resp, output bit ok);
        bit aw_d, w_d, aw_hs, w_hs;
        ok = 1'b0; resp = 2'b00; aw_d = 1'b0; w_d = 1'b0;
        S_AXI_awaddr = addr; S_AXI_wdata = data; S_AXI_wstrb = strb;
        S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_bready = (bstall == 0);
        for (int k = 0; k < 20 && !(aw_d && w_d); k++) begin
            @(negedge ACLK);
            aw_hs = S_AXI_awvalid && S_AXI_awready;
            w_hs  = S_AXI_wvalid && S_AXI_wready;
            @(posedge ACLK); #1;
            if (aw_hs) begin aw_d = 1'b1; S_AXI_awvalid = 1'b0; end
            if (w_hs)  begin w_d  = 1'b1; S_AXI_wvalid  = 1'b0; end
        end
        if (!(aw_d && w_d)) begin
            S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_bready = 1'b1;
            check_value("wr_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            if (S_AXI_bvalid) break;
        end
        if (!S_AXI_bvalid) begin
            S_AXI_bready = 1'b1;
            check_value("bvalid_timeout", 32'd0, 32'd1);
            return;
        end
        resp = S_AXI_bresp;
        for (int s = 0; s < bstall; s++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check_value("b_hold", {29'd0, S_AXI_bvalid, S_AXI_bresp}, {29'd0, 1'b1, resp});
        end
        S_AXI_bready = 1'b1;
        @(posedge ACLK); #1;
        ok = 1'b1;
    endtask

    task automatic axi_read(input logic [13:0] addr, input int rstall,
                            output logic [31:0] data, output logic [1:0] resp, output int lat, output bit ok);
        bit hs;
        ok = 1'b0; data = '0; resp = '0; lat = 0; hs = 1'b0;
        S_AXI_araddr = addr; S_AXI_arvalid = 1'b1; S_AXI_rready = (rstall == 0);
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            hs = S_AXI_arvalid && S_AXI_arready;
            @(posedge ACLK); #1;
            if (hs) break;
        end
        S_AXI_arvalid = 1'b0;
        if (!hs) begin
            S_AXI_rready = 1'b1;
            check_value("ar_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge ACLK);
            lat++;
            if (S_AXI_rvalid) break;
        end
        if (!S_AXI_rvalid) begin
            S_AXI_rready = 1'b1;
            check_value("rvalid_timeout", 32'd0, 32'd1);
            return;
        end
        data = S_AXI_rdata; resp = S_AXI_rresp;
        for (int s = 0; s < rstall; s++) begin
            @(posedge ACLK); #1;
            @(negedge ACLK);
            check_value("r_hold_data", S_AXI_rdata, data);
            check_value("r_hold_ctl", {29'd0, S_AXI_rvalid, S_AXI_rresp}, {29'd0, 1'b1, resp});
        end
        S_AXI_rready = 1'b1;
        @(posedge ACLK); #1;
        ok = 1'b1;
    endtask

    // Write plus comparison of response, port activity, start pulse and model update.
    task automatic do_write(input logic [13:0] addr, input logic [31:0] data, input logic [3:0] strb, input int bstall);
        int en0, wr0, st0, region, idx;
        logic [1:0] resp;
        bit ok, err, is_mem, fire;
        en0 = en_cnt; wr0 = wr_cnt; st0 = start_cnt;
        region = int'(addr) / 4096; idx = (int'(addr) % 4096) / 4;
        err    = model_err(int'(addr));
        is_mem = !err && (region < 2);
        fire   = !err && (region == 2) && (idx == 0) && strb[0] && data[0];
        axi_write(addr, data, strb, bstall, resp, ok);
        if (!ok) return;
        check_value("bresp", 32'(resp), err ? 32'd2 : 32'd0);
        check_value("wr_mem_en_cycles", 32'(en_cnt - en0), is_mem ? 32'd1 : 32'd0);
        check_value("wr_mem_writes", 32'(wr_cnt - wr0), (is_mem && strb != 4'd0) ? 32'd1 : 32'd0);
        check_value("start_cycles", 32'(start_cnt - st0), fire ? 32'd1 : 32'd0);
        if (is_mem && strb != 4'd0) begin
            check_value("wr_port_ctl", {17'd0, last_wr_sel, last_wr_addr, last_wr_we},
                        {17'd0, (region == 1), 10'(idx), strb});
            check_value("wr_port_data", last_wr_data, data);
        end
        if (is_mem) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    if (region == 1) ref_wgt[idx][8*b +: 8] = data[8*b +: 8];
                    else             ref_img[idx][8*b +: 8] = data[8*b +: 8];
                end
            end
        end
        if (fire && !done) ref_sticky = 1'b0;
    endtask

    task automatic do_read(input logic [13:0] addr, input int rstall);
        int en0, region, idx, lat;
        logic [31:0] data, exp;
        logic [1:0] resp;
        bit ok, err, is_mem;
        en0 = en_cnt;
        region = int'(addr) / 4096; idx = (int'(addr) % 4096) / 4;
        err    = model_err(int'(addr));
        is_mem = !err && (region < 2);
        if (err)              exp = 32'd0;
        else if (region == 0) exp = ref_img[idx];
        else if (region == 1) exp = ref_wgt[idx];
        else if (idx == 1)    exp = {31'd0, ref_sticky};
        else                  exp = 32'd0;
        axi_read(addr, rstall, data, resp, lat, ok);
        if (!ok) return;
        check_value("rresp", 32'(resp), err ? 32'd2 : 32'd0);
        check_value("rdata", data, exp);
        check_value("rd_mem_en_cycles", 32'(en_cnt - en0), is_mem ? 32'd1 : 32'd0);
        check_value("rd_latency", 32'(lat), 32'd3);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] d;
        logic [13:0] a;
        int lat, wr0, region, idx;
        bit got;
        for (int i = 0; i < 1024; i++) begin
            img_bram[i] = '0; wgt_bram[i] = '0; ref_img[i] = '0; ref_wgt[i] = '0;
        end

        // reset state
        repeat (3) @(posedge ACLK);
        #1;
        @(negedge ACLK);
        check_value("rst_ready", {29'd0, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'd0);
        check_value("rst_valid", {28'd0, S_AXI_bvalid, S_AXI_rvalid, start, mem_en}, 32'd0);
        check_value("rst_resp", {24'd0, mem_we, S_AXI_bresp, S_AXI_rresp}, 32'd0);
        check_value("rst_rdata", S_AXI_rdata, 32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        check_value("rel_ready", {29'd0, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'd7);

        // fill every weight word with its index, then read all back
        for (int i = 0; i < 784; i++) do_write(14'(14'h1000 + 4 * i), 32'(i), 4'hF, 0);
        for (int i = 0; i < 784; i++) do_read(14'(14'h1000 + 4 * i), 0);

        // W presented three cycles ahead of AW to image word 2
        d = 32'hA5A5_0002; wr0 = wr_cnt;
        S_AXI_wdata = d; S_AXI_wstrb = 4'hF; S_AXI_wvalid = 1'b1;
        @(negedge ACLK);
        check_value("early_w_ready", {31'd0, S_AXI_wready}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_wvalid = 1'b0;
        check_value("wready_drop", {31'd0, S_AXI_wready}, 32'd0);
        repeat (2) @(posedge ACLK);
        #1;
        check_value("no_early_write", 32'(wr_cnt - wr0), 32'd0);
        S_AXI_awaddr = 14'h0008; S_AXI_awvalid = 1'b1;
        @(negedge ACLK);
        check_value("late_aw_ready", {31'd0, S_AXI_awready}, 32'd1);
        @(posedge ACLK); #1;
        S_AXI_awvalid = 1'b0;
        @(negedge ACLK);
        check_value("late_aw_port", {16'd0, mem_en, mem_sel, mem_addr, mem_we},
                    {16'd0, 1'b1, 1'b0, 10'd2, 4'hF});
        check_value("late_aw_bvalid_n1", {31'd0, S_AXI_bvalid}, 32'd0);
        @(negedge ACLK);
        check_value("late_aw_bvalid_n2", {29'd0, S_AXI_bvalid, S_AXI_bresp}, 32'd4);
        @(posedge ACLK); #1;
        check_value("late_aw_writes", 32'(wr_cnt - wr0), 32'd1);
        ref_img[2] = d;
        do_read(14'h0008, 0);

        // out-of-range and reserved accesses
        do_write(14'h0C40, $urandom, 4'hF, 0);
        do_read(14'h3000, 0);
        do_write(14'h3000, $urandom, 4'hF, 1);
        do_read(14'h0C40, 1);
        do_read(14'h1C40, 0);
        do_read(14'h2008, 0);
        do_write(14'h2004, 32'hFFFF_FFFF, 4'hF, 0);

        // randomized traffic against the model
        for (int t = 0; t < 300; t++) begin
            region = $urandom_range(0, 9);
            if (region < 4)      region = 0;
            else if (region < 8) region = 1;
            else if (region == 8) region = 2;
            else                 region = 3;
            if (region == 2)                    idx = $urandom_range(1, 3);
            else if ($urandom_range(0, 7) == 0) idx = $urandom_range(784, 1023);
            else                                idx = $urandom_range(0, 31);
            a = 14'(region * 4096 + idx * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2));
            else                           do_read(a, $urandom_range(0, 2));
        end

        // start pulse and sticky done
        done = 1'b1;
        @(posedge ACLK); #1;
        ref_sticky = 1'b1;
        do_write(14'h2000, 32'd1, 4'hF, 0);
        check_value("start_with_bvalid", 32'(start_bad), 32'd0);
        do_read(14'h2004, 0);
        do_read(14'h2000, 0);
        done = 1'b0;
        do_write(14'h2000, 32'd0, 4'hF, 0);
        do_read(14'h2004, 0);
        do_write(14'h2000, 32'd1, 4'hF, 0);
        do_read(14'h2004, 0);
        done = 1'b1;
        @(posedge ACLK); #1;
        done = 1'b0;
        ref_sticky = 1'b1;
        do_read(14'h2004, 0);

        // coinciding write and read to the same image word
        d = $urandom;
        S_AXI_awaddr = 14'h0014; S_AXI_wdata = d; S_AXI_wstrb = 4'hF; S_AXI_araddr = 14'h0014;
        S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_arvalid = 1'b1;
        @(negedge ACLK);
        check_value("coinc_ready", {29'd0, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'd7);
        @(posedge ACLK); #1;
        S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0; S_AXI_arvalid = 1'b0;
        @(negedge ACLK);
        check_value("coinc_first_write", {17'd0, mem_en, mem_addr, mem_we}, {17'd0, 1'b1, 10'd5, 4'hF});
        @(negedge ACLK);
        check_value("coinc_then_read", {17'd0, mem_en, mem_addr, mem_we}, {17'd0, 1'b1, 10'd5, 4'h0});
        lat = 0; got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            lat++;
            if (S_AXI_rvalid) begin got = 1'b1; break; end
        end
        check_value("coinc_rvalid_seen", {31'd0, got}, 32'd1);
        check_value("coinc_rlat", 32'(lat), 32'd2);
        check_value("coinc_rdata", S_AXI_rdata, d);
        check_value("coinc_rresp", 32'(S_AXI_rresp), 32'd0);
        @(posedge ACLK); #1;
        ref_img[5] = d;
        do_read(14'h0014, 0);

        // reset while a write response is pending
        d = $urandom;
        S_AXI_awaddr = 14'h0030; S_AXI_wdata = d; S_AXI_wstrb = 4'hF;
        S_AXI_awvalid = 1'b1; S_AXI_wvalid = 1'b1; S_AXI_bready = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_awvalid = 1'b0; S_AXI_wvalid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge ACLK);
            if (S_AXI_bvalid) begin got = 1'b1; break; end
        end
        check_value("pend_bvalid", {31'd0, got}, 32'd1);
        ref_img[12] = d;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        check_value("rst_bvalid_drop", {28'd0, S_AXI_bvalid, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'd0);
        @(negedge ACLK);
        ARESET = 1'b0;
        ref_sticky = 1'b0;
        @(posedge ACLK); #1;
        check_value("post_rst_ready", {29'd0, S_AXI_awready, S_AXI_wready, S_AXI_arready}, 32'd7);
        S_AXI_bready = 1'b1;
        do_read(14'h0030, 0);
        do_read(14'h2004, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
`default_nettype wire
